// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared types and constants for the UDP receive path.
//   state_e       - receive FSM states (header parse, payload forward, discard)
//   OFS_*         - byte offsets into the combined 20-byte IPv4 + 8-byte UDP header
//   HDR_LEN/LAST  - header length and index of its final byte
//   ones_add16    - 16-bit ones-complement add (end-around carry)
package udp_rx_pkg;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_e;

  localparam logic [4:0] OFS_VER      = 5'd0;
  localparam logic [4:0] OFS_FRAG     = 5'd6;
  localparam logic [4:0] OFS_PROTO    = 5'd9;
  localparam logic [4:0] OFS_SRC_IP   = 5'd12;
  localparam logic [4:0] OFS_DST_IP   = 5'd16;
  localparam logic [4:0] OFS_IP_END   = 5'd19;
  localparam logic [4:0] OFS_SRC_PORT = 5'd20;
  localparam logic [4:0] OFS_DST_PORT = 5'd22;
  localparam logic [4:0] OFS_UDP_LEN  = 5'd24;
  localparam logic [4:0] HDR_LEN      = 5'd28;
  localparam logic [4:0] HDR_LAST     = HDR_LEN - 5'd1;

  localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
  localparam logic [7:0]  IPPROTO_UDP  = 8'd17;
  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

  // Ones-complement add: the carry out of bit 15 is folded back into bit 0.
  // A single fold is enough because 16'hFFFF + 16'hFFFF folds to 16'hFFFF.
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_rx_csum16_acc.sv
// csum16_acc: ones-complement 16-bit checksum accumulator fed one byte at a time.
// Byte pairs are assembled with the first (even) byte as the MSB.
//   clk, reset    - clock, synchronous active-high reset
//   clr_i         - restart the sum and the byte-pair phase (wins over byte_valid_i)
//   byte_valid_i  - byte_i is consumed this cycle
//   byte_i        - input byte
//   sum_o         - running sum including any word completed by this cycle's byte
module csum16_acc
  import udp_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q, sum_d;
  logic [7:0]  msb_q, msb_d;
  logic        odd_q, odd_d;

  // odd_q set means an MSB is parked in msb_q waiting for its LSB partner.
  always_comb begin
    sum_d = sum_q;
    msb_d = msb_q;
    odd_d = odd_q;
    if (clr_i) begin
      sum_d = 16'd0;
      msb_d = 8'd0;
      odd_d = 1'b0;
    end else if (byte_valid_i) begin
      if (!odd_q) begin
        msb_d = byte_i;
        odd_d = 1'b1;
      end else begin
        sum_d = ones_add16(sum_q, {msb_q, byte_i});
        odd_d = 1'b0;
      end
    end
  end

  // Exposing the next value lets the caller judge the sum on the same
  // transfer that delivers the final byte.
  assign sum_o = sum_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 16'd0;
      msb_q <= 8'd0;
      odd_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      msb_q <= msb_d;
      odd_q <= odd_d;
    end
  end

endmodule

// File: rtl/udp_rx.sv
// udp_rx: strips and validates a fixed IPv4 (no options) + UDP header from the
// MAC payload byte stream and forwards only the UDP payload of datagrams sent
// to LOCAL_IP (or broadcast) : LOCAL_PORT.
//   clk, reset            - 125 MHz clock, synchronous active-high reset
//   ready_in/valid_in     - MAC-side handshake; data_in byte, eof_in marks frame end
//   ready_out/valid_out   - application handshake; data_out byte, eof_out on last
//   src_ip, src_port      - source of the most recently accepted datagram
//   payload_len           - UDP length minus the 8-byte UDP header
//   frame_drop            - one-cycle pulse when a complete header is rejected
//   trunc_err             - one-cycle pulse when the frame ends before payload_len
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8010A,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready_in,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  input  logic        eof_in,
  input  logic        ready_out,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic        eof_out,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] payload_len,
  output logic        frame_drop,
  output logic        trunc_err
);

  state_e      state_q;
  logic [4:0]  idx_q;
  logic        pass_q;
  logic [31:0] src_ip_sh_q;
  logic [15:0] src_port_sh_q;
  logic [31:0] dst_ip_q;
  logic [15:0] dst_port_q;
  logic [15:0] udp_len_q;
  logic [15:0] rem_q;

  logic        valid_q;
  logic [7:0]  data_q;
  logic        eof_q;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q;
  logic [15:0] payload_len_q;
  logic        frame_drop_q;
  logic        trunc_err_q;

  logic        in_acc;
  logic        hdr_acc;
  logic        byte_ok_d;
  logic        pass_d;
  logic        hdr_ok_d;
  logic        csum_clr;
  logic        csum_byte;
  logic [15:0] csum_sum;

  // In PAYLOAD a new byte may only enter when the output register is empty
  // or being drained this cycle; the other states never stall the MAC.
  always_comb begin
    ready_in = 1'b1;
    if (state_q == PAYLOAD) ready_in = ~valid_q | ready_out;
  end

  assign in_acc  = valid_in & ready_in;
  assign hdr_acc = in_acc & (state_q == HDR);

  // The checksum restarts whenever we are not parsing a header, and on an
  // aborted header so the next frame starts clean.
  assign csum_clr  = (state_q != HDR) | (hdr_acc & eof_in);
  assign csum_byte = hdr_acc & (idx_q <= OFS_IP_END);

  csum16_acc u_csum (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (csum_clr),
    .byte_valid_i (csum_byte),
    .byte_i       (data_in),
    .sum_o        (csum_sum)
  );

  // Per-byte header checks folded into the sticky pass flag, plus the final
  // address/port/length decision taken when the last header byte arrives.
  always_comb begin
    byte_ok_d = 1'b1;
    if (idx_q == OFS_VER && data_in != IPV4_VER_IHL) byte_ok_d = 1'b0;
    if (idx_q == OFS_FRAG && (data_in & 8'h3F) != 8'h00) byte_ok_d = 1'b0;
    if (idx_q == OFS_FRAG + 5'd1 && data_in != 8'h00) byte_ok_d = 1'b0;
    if (idx_q == OFS_PROTO && data_in != IPPROTO_UDP) byte_ok_d = 1'b0;
    if (idx_q == OFS_IP_END && csum_sum != 16'hFFFF) byte_ok_d = 1'b0;
    pass_d   = pass_q & byte_ok_d;
    hdr_ok_d = pass_d
             & ((dst_ip_q == LOCAL_IP) | (dst_ip_q == 32'hFFFF_FFFF))
             & (dst_port_q == LOCAL_PORT)
             & (udp_len_q >= 16'd9);
  end

  // Receive FSM with all outputs registered. Multi-byte header fields are
  // shifted in MSB first; the source fields go to shadow registers so the
  // visible src_ip/src_port only change when a datagram is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HDR;
      idx_q         <= 5'd0;
      pass_q        <= 1'b1;
      src_ip_sh_q   <= 32'd0;
      src_port_sh_q <= 16'd0;
      dst_ip_q      <= 32'd0;
      dst_port_q    <= 16'd0;
      udp_len_q     <= 16'd0;
      rem_q         <= 16'd0;
      valid_q       <= 1'b0;
      data_q        <= 8'd0;
      eof_q         <= 1'b0;
      src_ip_q      <= 32'd0;
      src_port_q    <= 16'd0;
      payload_len_q <= 16'd0;
      frame_drop_q  <= 1'b0;
      trunc_err_q   <= 1'b0;
    end else begin
      frame_drop_q <= 1'b0;
      trunc_err_q  <= 1'b0;
      if (valid_q && ready_out) valid_q <= 1'b0;

      unique case (state_q)
        HDR: begin
          if (hdr_acc) begin
            if (idx_q >= OFS_SRC_IP && idx_q < OFS_DST_IP)
              src_ip_sh_q <= {src_ip_sh_q[23:0], data_in};
            if (idx_q >= OFS_DST_IP && idx_q < OFS_SRC_PORT)
              dst_ip_q <= {dst_ip_q[23:0], data_in};
            if (idx_q >= OFS_SRC_PORT && idx_q < OFS_DST_PORT)
              src_port_sh_q <= {src_port_sh_q[7:0], data_in};
            if (idx_q >= OFS_DST_PORT && idx_q < OFS_UDP_LEN)
              dst_port_q <= {dst_port_q[7:0], data_in};
            if (idx_q >= OFS_UDP_LEN && idx_q < OFS_UDP_LEN + 5'd2)
              udp_len_q <= {udp_len_q[7:0], data_in};

            if (eof_in) begin
              // Runt frame: silently forget it.
              idx_q  <= 5'd0;
              pass_q <= 1'b1;
            end else if (idx_q == HDR_LAST) begin
              idx_q  <= 5'd0;
              pass_q <= 1'b1;
              if (hdr_ok_d) begin
                state_q       <= PAYLOAD;
                rem_q         <= udp_len_q - UDP_HDR_LEN;
                payload_len_q <= udp_len_q - UDP_HDR_LEN;
                src_ip_q      <= src_ip_sh_q;
                src_port_q    <= src_port_sh_q;
              end else begin
                state_q      <= DROP;
                frame_drop_q <= 1'b1;
              end
            end else begin
              idx_q  <= idx_q + 5'd1;
              pass_q <= pass_d;
            end
          end
        end

        PAYLOAD: begin
          if (in_acc) begin
            data_q  <= data_in;
            valid_q <= 1'b1;
            eof_q   <= (rem_q == 16'd1) | eof_in;
            rem_q   <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              // Anything after the last payload byte is Ethernet padding.
              state_q <= eof_in ? HDR : DROP;
              idx_q   <= 5'd0;
            end else if (eof_in) begin
              trunc_err_q <= 1'b1;
              state_q     <= HDR;
              idx_q       <= 5'd0;
            end
          end
        end

        DROP: begin
          if (in_acc && eof_in) begin
            state_q <= HDR;
            idx_q   <= 5'd0;
          end
        end

        default: begin
          state_q <= HDR;
          idx_q   <= 5'd0;
        end
      endcase
    end
  end

  assign valid_out   = valid_q;
  assign data_out    = data_q;
  assign eof_out     = eof_q;
  assign src_ip      = src_ip_q;
  assign src_port    = src_port_q;
  assign payload_len = payload_len_q;
  assign frame_drop  = frame_drop_q;
  assign trunc_err   = trunc_err_q;

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- Consumes the MAC RX payload byte stream, which is the Ethernet payload after header strip and CRC-qualified commit, one frame per eof.
- Parses a fixed 20-byte IPv4 header and an 8-byte UDP header, validates them, and filters on local IP and port.
- Forwards only the UDP payload bytes, with eof on the last one.
- Sits between the MAC and the application; frames not addressed to the local port are silently discarded.

Parameters:
- LOCAL_IP, 32'hC0A8010A, destination IPv4 address accepted. 32'hFFFFFFFF is always accepted as well.
- LOCAL_PORT, 16'd5000, UDP destination port accepted.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  synchronous, active-high.
- ready_in  out  1  sink-side ready to the MAC.
- valid_in  in  1  MAC byte valid.
- data_in  in  8  MAC byte.
- eof_in  in  1  last byte of MAC frame.
- ready_out  in  1  application ready.
- valid_out  out  1  payload byte valid.
- data_out  out  8  payload byte.
- eof_out  out  1  last payload byte.
- src_ip  out  32  source IP of current datagram.
- src_port  out  16  source port of current datagram.
- payload_len  out  16  UDP length minus 8.
- frame_drop  out  1  1-cycle pulse when a frame is rejected.
- trunc_err  out  1  1-cycle pulse when a frame ends before payload_len bytes.

Behaviour:
- A byte transfers on valid_in & ready_in.
- Byte index counter idx is 5 bits, cleared on reset and on every transition to HDR.

- State HDR:
  - ready_in=1.
  - idx counts 0..27.
  - Byte 0 must equal 8'h45; IP options are unsupported.
  - Bytes 6-7 & 16'h3FFF must be 0; fragments are rejected.
  - Byte 9 must equal 8'd17.
  - Bytes 16-19 must equal LOCAL_IP or all-ones.
  - Bytes 22-23 must equal LOCAL_PORT.
  - Bytes 12-15 are latched to src_ip; bytes 20-21 to src_port.
  - Bytes 24-25 (udp_len) must be >= 9; udp_len=8 is dropped.
  - Accumulated checks form a sticky pass flag.
- IP checksum:
  - 16-bit words are formed from byte pairs (even index = MSB) over idx 0..19.
  - Each word is added with end-around carry via a 17-bit add, folding the carry in.
  - The result must equal 16'hFFFF at idx 19.
  - The UDP checksum is ignored.
- Decision on the transfer of idx 27:
  - Pass: go to PAYLOAD, load remaining count = udp_len-8, drive payload_len.
  - Fail: pulse frame_drop, go to DROP.
  - eof_in on any header byte: discard the frame, no frame_drop, return to HDR.
- State PAYLOAD:
  - ready_in = ~valid_out | ready_out.
  - An accepted byte is loaded into the output register; valid_out rises the next cycle (latency 1).
  - Remaining count decrements per accepted byte.
  - When the count reaches 1, that byte carries eof_out=1.
    - If eof_in is also set, go to HDR.
    - Otherwise go to DROP, which swallows Ethernet padding without a frame_drop pulse.
  - If eof_in arrives with count > 1: that byte carries eof_out=1, trunc_err pulses, go to HDR.
- State DROP: ready_in=1, discard bytes until eof_in, then go to HDR.
- Output register holds data_out/eof_out stable while valid_out & ~ready_out; no byte is lost or duplicated.
- src_ip, src_port and payload_len stay stable from the PAYLOAD entry until the next accepted datagram.
- Reset, including mid-frame:
  - valid_out=0, eof_out=0, data_out=0, frame_drop=0, trunc_err=0.
  - src_ip=0, src_port=0, payload_len=0.
  - State HDR, idx=0.
  - Remaining bytes of the interrupted frame are parsed as a new header and will fail checks (drop).

Decomposition:
- Package udp_rx_pkg holds:
  - state enum {HDR, PAYLOAD, DROP};
  - header byte-offset localparams (OFS_VER, OFS_FRAG, OFS_PROTO, OFS_SRC_IP, OFS_DST_IP, OFS_SRC_PORT, OFS_DST_PORT, OFS_UDP_LEN, HDR_LEN=28);
  - IPPROTO_UDP=8'd17.
- One sub-module, csum16_acc: a ones-complement 16-bit accumulator with clear, byte-in and byte-pair assembly. It is reused later by the UDP TX stage.

Test Plan:
- Valid datagram to 192.168.1.10:5000 from 10.0.0.1:1234, udp_len=12, payload DE AD BE EF, plus 14 padding bytes, ready_out=1 -> out DE,AD,BE,EF with eof on EF; src_ip=32'h0A000001, src_port=1234, payload_len=4; no frame_drop.
- Same frame with header checksum bit 0 flipped -> no valid_out; frame_drop pulses once, on the cycle after idx 27 transfers.
- Dest port 5001, then a frame with byte 0 = 8'h46 -> two frame_drop pulses, no output; a following valid frame is forwarded intact.
- 64-byte payload with ready_out pseudo-random at 33% duty -> output byte sequence identical to input, exactly one eof_out, ready_in never accepts while the register is full and stalled.
- eof_in at header idx 10, then a valid frame -> first frame produces nothing and no pulse; second is forwarded normally.
- udp_len=108 but MAC eof after 10 payload bytes -> 10 bytes out, eof_out on the 10th, trunc_err pulses once.
- reset asserted mid-payload -> all outputs zero next cycle; the next valid frame is forwarded correctly.
